// File: rtl/ordered_sets_decoder.sv
// Aurora ordered-set decoder (receive side).
// Consumes the 8-bit intermediate character stream from the 8b/10b decoder
// and emits one strobe per recognised ordered set. It also emits an error
// strobe for malformed or aborted sequences and for unknown K characters.
// A one-character lookahead separates a lone K (BC) from the start of an
// SP/SPA/VER sequence.
// Optional feature: define ORDERED_SETS_DECODER_ERR_CNT_EN to add a
// saturating error counter on port err_cnt.

package aurora_pkg;
    localparam int INTERMEDIATE_DATA_SIZE = 8;

    typedef enum logic [3:0] {
        I   = 4'd0,
        SP  = 4'd1,
        SPA = 4'd2,
        VER = 4'd3,
        SCP = 4'd4,
        ECP = 4'd5,
        CC  = 4'd6,
        P   = 4'd7,
        SUF = 4'd8,
        K   = 4'd9,
        R   = 4'd10,
        A   = 4'd11,
        SNF = 4'd12
    } ordered_sets_e;
endpackage

module ordered_sets_decoder #(
    parameter int ERR_CNT_W = 16
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [aurora_pkg::INTERMEDIATE_DATA_SIZE-1:0] rx_data,
    input  logic                                         rx_is_k,
    input  logic                                         rx_valid,
    output logic                                         os_valid,
    output aurora_pkg::ordered_sets_e                    os_type,
    output logic                                         os_err
`ifdef ORDERED_SETS_DECODER_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0]                         err_cnt
`endif
);

    localparam int DW = aurora_pkg::INTERMEDIATE_DATA_SIZE;

    // Control characters
    localparam logic [DW-1:0] CH_K28_5 = 8'hBC;
    localparam logic [DW-1:0] CH_K28_0 = 8'h1C;
    localparam logic [DW-1:0] CH_K28_2 = 8'h5C;
    localparam logic [DW-1:0] CH_K28_3 = 8'h7C;
    localparam logic [DW-1:0] CH_K28_4 = 8'h9C;
    localparam logic [DW-1:0] CH_K28_6 = 8'hDC;
    localparam logic [DW-1:0] CH_K23_7 = 8'hF7;
    localparam logic [DW-1:0] CH_K27_7 = 8'hFB;
    localparam logic [DW-1:0] CH_K29_7 = 8'hFD;
    localparam logic [DW-1:0] CH_K30_7 = 8'hFE;

    // Data characters used as the repeated body of SP / SPA / VER
    localparam logic [DW-1:0] CH_D10_2 = 8'h4A;
    localparam logic [DW-1:0] CH_D12_1 = 8'h2C;
    localparam logic [DW-1:0] CH_D8_7  = 8'hE8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEQ,
        ST_SCP,
        ST_ECP,
        ST_CC
    } state_e;

    if (ERR_CNT_W < 1) begin : g_err_cnt_w_invalid
        $error("ordered_sets_decoder: ERR_CNT_W must be at least 1");
    end

    state_e                    state_q, state_d;
    logic [DW-1:0]             cur_q, cur_d;
    logic                      cur_k_q, cur_k_d;
    logic                      cur_vld_q, cur_vld_d;
    logic [DW-1:0]             exp_q, exp_d;
    logic [1:0]                rep_q, rep_d;
    logic                      os_valid_q, os_valid_d;
    aurora_pkg::ordered_sets_e os_type_q, os_type_d;
    logic                      os_err_q, os_err_d;
    logic                      restart;

    // Lookahead load plus one decision on cur per valid cycle; a mismatch
    // re-decides cur as a fresh IDLE start in the same cycle.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        cur_k_d    = cur_k_q;
        cur_vld_d  = cur_vld_q;
        exp_d      = exp_q;
        rep_d      = rep_q;
        os_valid_d = 1'b0;
        os_type_d  = os_type_q;
        os_err_d   = 1'b0;
        restart    = 1'b0;

        if (rx_valid) begin
            cur_d     = rx_data;
            cur_k_d   = rx_is_k;
            cur_vld_d = 1'b1;

            if (cur_vld_q) begin
                unique case (state_q)
                    ST_IDLE: begin
                        restart = 1'b1;
                    end
                    ST_SEQ: begin
                        if (!cur_k_q && (cur_q == exp_q)) begin
                            if (rep_q == 2'd2) begin
                                os_valid_d = 1'b1;
                                state_d    = ST_IDLE;
                                if (exp_q == CH_D10_2) begin
                                    os_type_d = aurora_pkg::SP;
                                end else if (exp_q == CH_D12_1) begin
                                    os_type_d = aurora_pkg::SPA;
                                end else begin
                                    os_type_d = aurora_pkg::VER;
                                end
                            end else begin
                                rep_d = rep_q + 2'd1;
                            end
                        end else begin
                            os_err_d = 1'b1;
                            restart  = 1'b1;
                        end
                    end
                    ST_SCP: begin
                        if (cur_k_q && (cur_q == CH_K27_7)) begin
                            os_valid_d = 1'b1;
                            os_type_d  = aurora_pkg::SCP;
                            state_d    = ST_IDLE;
                        end else begin
                            os_err_d = 1'b1;
                            restart  = 1'b1;
                        end
                    end
                    ST_ECP: begin
                        if (cur_k_q && (cur_q == CH_K30_7)) begin
                            os_valid_d = 1'b1;
                            os_type_d  = aurora_pkg::ECP;
                            state_d    = ST_IDLE;
                        end else begin
                            os_err_d = 1'b1;
                            restart  = 1'b1;
                        end
                    end
                    ST_CC: begin
                        if (cur_k_q && (cur_q == CH_K23_7)) begin
                            os_valid_d = 1'b1;
                            os_type_d  = aurora_pkg::CC;
                            state_d    = ST_IDLE;
                        end else begin
                            os_err_d = 1'b1;
                            restart  = 1'b1;
                        end
                    end
                    default: begin
                        restart = 1'b1;
                    end
                endcase

                if (restart) begin
                    state_d = ST_IDLE;
                    if (cur_k_q) begin
                        case (cur_q)
                            CH_K28_5: begin
                                if (!rx_is_k && ((rx_data == CH_D10_2) ||
                                                 (rx_data == CH_D12_1) ||
                                                 (rx_data == CH_D8_7))) begin
                                    state_d = ST_SEQ;
                                    exp_d   = rx_data;
                                    rep_d   = 2'd0;
                                end else begin
                                    os_valid_d = 1'b1;
                                    os_type_d  = aurora_pkg::K;
                                end
                            end
                            CH_K28_0: begin
                                os_valid_d = 1'b1;
                                os_type_d  = aurora_pkg::R;
                            end
                            CH_K28_3: begin
                                os_valid_d = 1'b1;
                                os_type_d  = aurora_pkg::A;
                            end
                            CH_K28_4: begin
                                os_valid_d = 1'b1;
                                os_type_d  = aurora_pkg::P;
                            end
                            CH_K28_6: begin
                                os_valid_d = 1'b1;
                                os_type_d  = aurora_pkg::SNF;
                            end
                            CH_K28_2: state_d = ST_SCP;
                            CH_K29_7: state_d = ST_ECP;
                            CH_K23_7: state_d = ST_CC;
                            default:  os_err_d = 1'b1;
                        endcase
                    end
                end
            end
        end
    end

    // State, lookahead and registered output strobes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            cur_k_q    <= 1'b0;
            cur_vld_q  <= 1'b0;
            exp_q      <= '0;
            rep_q      <= 2'd0;
            os_valid_q <= 1'b0;
            os_type_q  <= aurora_pkg::I;
            os_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            cur_k_q    <= cur_k_d;
            cur_vld_q  <= cur_vld_d;
            exp_q      <= exp_d;
            rep_q      <= rep_d;
            os_valid_q <= os_valid_d;
            os_type_q  <= os_type_d;
            os_err_q   <= os_err_d;
        end
    end

    assign os_valid = os_valid_q;
    assign os_type  = os_type_q;
    assign os_err   = os_err_q;

`ifdef ORDERED_SETS_DECODER_ERR_CNT_EN
    localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Count each error strobe, holding at all-ones once saturated
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (os_err_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_ONE;
        end
    end

    // Error counter register, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_ordered_sets_decoder.sv
// Testbench for ordered_sets_decoder: a table-driven prefix-matching model
// checked every cycle, plus directed steps with hand-computed expectations.
module tb_ordered_sets_decoder;
    import aurora_pkg::*;

    localparam int CW = 2;
    localparam logic [CW-1:0] CNT_MAX = 2'b11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_is_k = 1'b0;
    logic          rx_valid = 1'b0;
    logic          os_valid;
    ordered_sets_e os_type;
    logic          os_err;
`ifdef ORDERED_SETS_DECODER_ERR_CNT_EN
    logic [CW-1:0] err_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ordered_sets_decoder #(.ERR_CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_is_k  (rx_is_k),
        .rx_valid (rx_valid),
        .os_valid (os_valid),
        .os_type  (os_type),
        .os_err   (os_err)
`ifdef ORDERED_SETS_DECODER_ERR_CNT_EN
        ,
        .err_cnt  (err_cnt)
`endif
    );

    task automatic check1(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // ---------------- reference model: set table + prefix matching --------
    typedef logic [8:0] ch_t;

    ch_t           set_ch [11][4];
    int            set_len [11];
    ordered_sets_e set_ty [11];

    function automatic ch_t kc(input logic [7:0] b);
        return {1'b1, b};
    endfunction

    function automatic ch_t dc(input logic [7:0] b);
        return {1'b0, b};
    endfunction

    initial begin
        set_len = '{4, 4, 4, 2, 2, 2, 1, 1, 1, 1, 1};
        set_ty  = '{SP, SPA, VER, SCP, ECP, CC, P, K, R, A, SNF};
        set_ch[0]  = '{kc(8'hBC), dc(8'h4A), dc(8'h4A), dc(8'h4A)};
        set_ch[1]  = '{kc(8'hBC), dc(8'h2C), dc(8'h2C), dc(8'h2C)};
        set_ch[2]  = '{kc(8'hBC), dc(8'hE8), dc(8'hE8), dc(8'hE8)};
        set_ch[3]  = '{kc(8'h5C), kc(8'hFB), 9'h0, 9'h0};
        set_ch[4]  = '{kc(8'hFD), kc(8'hFE), 9'h0, 9'h0};
        set_ch[5]  = '{kc(8'hF7), kc(8'hF7), 9'h0, 9'h0};
        set_ch[6]  = '{kc(8'h9C), 9'h0, 9'h0, 9'h0};
        set_ch[7]  = '{kc(8'hBC), 9'h0, 9'h0, 9'h0};
        set_ch[8]  = '{kc(8'h1C), 9'h0, 9'h0, 9'h0};
        set_ch[9]  = '{kc(8'h7C), 9'h0, 9'h0, 9'h0};
        set_ch[10] = '{kc(8'hDC), 9'h0, 9'h0, 9'h0};
    end

    ch_t           prefix [$];
    ch_t           m_cur;
    bit            have_cur = 1'b0;
    bit            exp_valid = 1'b0;
    bit            exp_err = 1'b0;
    ordered_sets_e exp_type = I;
    logic [CW-1:0] exp_cnt = '0;
    bit            model_ready = 1'b0;
    bit            type_known = 1'b0;

    function automatic bit is_prefix_of(input int s, input ch_t q [$]);
        if (q.size() > set_len[s]) return 1'b0;
        for (int i = 0; i < q.size(); i++)
            if (q[i] != set_ch[s][i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int complete_idx(input ch_t q [$]);
        for (int s = 0; s < 11; s++)
            if (set_len[s] == q.size() && is_prefix_of(s, q)) return s;
        return -1;
    endfunction

    // A candidate continues if some longer set extends it; when the
    // candidate is itself a full set, the lookahead must confirm the extension.
    function automatic bit continuing(input ch_t q [$], input ch_t nxt);
        bit full;
        full = (complete_idx(q) >= 0);
        for (int s = 0; s < 11; s++)
            if (set_len[s] > q.size() && is_prefix_of(s, q) &&
                (!full || set_ch[s][q.size()] == nxt)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_decide(input ch_t c, input ch_t nxt);
        ch_t cand [$];
        int  idx;
        cand = prefix;
        cand.push_back(c);
        for (int pass = 0; pass < 2; pass++) begin
            if (continuing(cand, nxt)) begin
                prefix = cand;
                return;
            end
            idx = complete_idx(cand);
            if (idx >= 0) begin
                exp_valid = 1'b1;
                exp_type  = set_ty[idx];
                prefix.delete();
                return;
            end
            if (cand.size() > 1) begin
                exp_err = 1'b1;
                prefix.delete();
                cand.delete();
                cand.push_back(c);
            end else begin
                if (c[8]) exp_err = 1'b1;
                prefix.delete();
                return;
            end
        end
    endfunction

    // Model advances on each rising edge with the same inputs the DUT samples
    always @(posedge clk) begin
        if (!rst_n) begin
            prefix.delete();
            have_cur    = 1'b0;
            exp_valid   = 1'b0;
            exp_err     = 1'b0;
            exp_type    = I;
            exp_cnt     = '0;
            model_ready = 1'b1;
            type_known  = 1'b1;
        end else begin
            exp_valid  = 1'b0;
            exp_err    = 1'b0;
            type_known = 1'b0;
            if (rx_valid) begin
                if (have_cur) model_decide(m_cur, {rx_is_k, rx_data});
                m_cur    = {rx_is_k, rx_data};
                have_cur = 1'b1;
                if (exp_err && exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 2'd1;
            end
        end
    end

    // Every cycle, compare DUT outputs with the model on the falling edge
    always @(negedge clk) begin
        if (model_ready) begin
            check1("os_valid", int'(os_valid), int'(exp_valid));
            check1("os_err", int'(os_err), int'(exp_err));
            if (exp_valid || type_known)
                check1("os_type", int'(os_type), int'(exp_type));
`ifdef ORDERED_SETS_DECODER_ERR_CNT_EN
            check1("err_cnt", int'(err_cnt), int'(exp_cnt));
`endif
        end
    end

    // ---------------- directed steps with literal expectations -----------
    typedef struct {
        bit            r;
        bit            v;
        bit            k;
        logic [7:0]    d;
        bit            ev;
        ordered_sets_e et;
        bit            ee;
        int            cnt;
    } step_t;

    step_t dir [$];

    function automatic void add(input bit r, input bit v, input bit k, input logic [7:0] d,
                                input bit ev, input ordered_sets_e et, input bit ee,
                                input int cnt);
        step_t s;
        s.r = r; s.v = v; s.k = k; s.d = d;
        s.ev = ev; s.et = et; s.ee = ee; s.cnt = cnt;
        dir.push_back(s);
    endfunction

    task automatic applyStimulus(input bit k, input logic [7:0] d, input bit v);
        rx_is_k  = k;
        rx_data  = d;
        rx_valid = v;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input step_t s);
        check1({name, ".valid"}, int'(os_valid), int'(s.ev));
        check1({name, ".err"}, int'(os_err), int'(s.ee));
        if (s.ev || s.r) check1({name, ".type"}, int'(os_type), int'(s.et));
`ifdef ORDERED_SETS_DECODER_ERR_CNT_EN
        if (s.cnt >= 0) check1({name, ".cnt"}, int'(err_cnt), s.cnt);
`endif
    endtask

    ch_t pool [14];
    ch_t pend [$];

    initial begin
        pool = '{kc(8'hBC), dc(8'h4A), dc(8'h2C), dc(8'hE8), kc(8'h1C), kc(8'h5C), kc(8'h7C),
                 kc(8'h9C), kc(8'hDC), kc(8'hF7), kc(8'hFB), kc(8'hFD), kc(8'hFE), dc(8'h00)};

        // SP with an idle gap inside, then 1C
        add(0,1,1,8'hBC, 0,I,0,-1);
        add(0,1,0,8'h4A, 0,I,0,-1);
        add(0,0,0,8'h00, 0,I,0,-1);
        add(0,1,0,8'h4A, 0,I,0,-1);
        add(0,1,0,8'h4A, 0,I,0,-1);
        add(0,1,1,8'h1C, 1,SP,0,-1);
        // R, lone K, P
        add(0,1,1,8'hBC, 1,R,0,-1);
        add(0,1,1,8'h9C, 1,K,0,-1);
        add(0,1,0,8'h00, 1,P,0,-1);
        // SCP, ECP, CC
        add(0,1,1,8'h5C, 0,I,0,-1);
        add(0,1,1,8'hFB, 0,I,0,-1);
        add(0,1,1,8'hFD, 1,SCP,0,-1);
        add(0,1,1,8'hFE, 0,I,0,-1);
        add(0,1,1,8'hF7, 1,ECP,0,-1);
        add(0,1,1,8'hF7, 0,I,0,-1);
        add(0,1,0,8'h00, 1,CC,0,-1);
        // SPA broken by 4A: error, 4A ignored
        add(0,1,1,8'hBC, 0,I,0,-1);
        add(0,1,0,8'h2C, 0,I,0,-1);
        add(0,1,0,8'h2C, 0,I,0,-1);
        add(0,1,0,8'h4A, 0,I,0,-1);
        add(0,1,0,8'h00, 0,I,1,-1);
        add(0,1,0,8'h00, 0,I,0,-1);
        // 5C,9C: error together with P
        add(0,1,1,8'h5C, 0,I,0,-1);
        add(0,1,1,8'h9C, 0,I,0,-1);
        add(0,1,0,8'h00, 1,P,1,-1);
        // BC,BC,4A x3: K then SP
        add(0,1,1,8'hBC, 0,I,0,-1);
        add(0,1,1,8'hBC, 1,K,0,-1);
        add(0,1,0,8'h4A, 0,I,0,-1);
        add(0,1,0,8'h4A, 0,I,0,-1);
        add(0,1,0,8'h4A, 0,I,0,-1);
        add(0,1,0,8'h00, 1,SP,0,-1);
        // Reset mid-VER discards progress silently
        add(0,1,1,8'hBC, 0,I,0,-1);
        add(0,1,0,8'hE8, 0,I,0,-1);
        add(1,0,0,8'h00, 0,I,0,0);
        add(0,1,0,8'hE8, 0,I,0,0);
        add(0,1,0,8'hE8, 0,I,0,0);
        add(0,1,0,8'h00, 0,I,0,0);
        // Five lone FB characters: five errors, counter saturates at 3
        add(0,1,1,8'hFB, 0,I,0,0);
        add(0,1,1,8'hFB, 0,I,1,1);
        add(0,1,1,8'hFB, 0,I,1,2);
        add(0,1,1,8'hFB, 0,I,1,3);
        add(0,1,1,8'hFB, 0,I,1,3);
        add(0,1,0,8'h00, 0,I,1,3);

        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset", '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, I, 1'b0, 0});
        rst_n = 1'b1;
        $display("[TB] directed steps: %0d", dir.size());

        foreach (dir[i]) begin
            if (dir[i].r) rst_n = 1'b0;
            applyStimulus(dir[i].k, dir[i].d, dir[i].v);
            rst_n = 1'b1;
            checkOutput($sformatf("dir%0d", i), dir[i]);
        end

        // Randomized traffic: whole sets mixed with loose and arbitrary characters
        for (int c = 0; c < 4000; c++) begin
            int pick;
            if (pend.size() == 0) begin
                pick = $urandom_range(0, 9);
                if (pick < 5) begin
                    int s;
                    s = $urandom_range(0, 10);
                    for (int j = 0; j < set_len[s]; j++) pend.push_back(set_ch[s][j]);
                end else if (pick < 8) begin
                    pend.push_back(pool[$urandom_range(0, 13)]);
                end else begin
                    pend.push_back({1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))});
                end
            end
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 7) == 0) begin
                applyStimulus(1'b0, 8'h00, 1'b0);
            end else begin
                ch_t ch;
                ch = pend.pop_front();
                applyStimulus(ch[8], ch[7:0], 1'b1);
            end
        end
        rst_n = 1'b1;
        repeat (4) applyStimulus(1'b0, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
